// File: rtl/record_playback_ctrl_pkg.sv
// record_playback_ctrl_pkg: shared state encoding and default sizing for the record/playback controller
package record_playback_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RECORD, PLAY_LOAD, PLAY_RUN} state_t;
    localparam int DEPTH_D = 8;
    localparam int DUR_W_D = 7;
    localparam int TICK_DIV_D = 100;
    function automatic int dur_max(input int w);
        return (2 ** w) - 1;
    endfunction
endpackage

// File: rtl/record_playback_ctrl_if.sv
// record_playback_ctrl_if: front-panel commands and light-driver outputs of the recorder
interface record_playback_ctrl_if #(
    parameter int IDX_W = 3
);
    logic sw_in, rec_start, play_start, stop, loop_en;
    logic play_out, rec_busy, play_busy, full, play_done;
    logic [IDX_W:0] entry_count;
    modport master(
        output sw_in, rec_start, play_start, stop, loop_en,
        input play_out, rec_busy, play_busy, full, entry_count, play_done
    );
    modport slave(
        input sw_in, rec_start, play_start, stop, loop_en,
        output play_out, rec_busy, play_busy, full, entry_count, play_done
    );
endinterface

// File: rtl/record_playback_ctrl_tick_gen.sv
// record_playback_ctrl_tick_gen: prescaler giving a 1-cycle tick every TICK_DIV cycles, restartable by clr
module record_playback_ctrl_tick_gen
    import record_playback_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_D
) (
    input  logic Div_CLK,
    input  logic Rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] cnt;
    assign tick = cnt == CW'(TICK_DIV - 1);
    always_ff @(posedge Div_CLK or negedge Rst_n) begin
        if (!Rst_n) cnt <= '0;
        else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/record_playback_ctrl.sv
// record_playback_ctrl: timestamps switch level changes into a level/duration store and replays them on play_out
module record_playback_ctrl
    import record_playback_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_D,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int DUR_W = DUR_W_D,
    parameter int TICK_DIV = TICK_DIV_D
) (
    input logic Div_CLK,
    input logic Rst_n,
    record_playback_ctrl_if.slave bus
);
    localparam logic [DUR_W-1:0] DUR_MAX = DUR_W'(dur_max(DUR_W));
    localparam logic [IDX_W:0] FULL_N = (IDX_W + 1)'(DEPTH);
    state_t state_q, state_d;
    logic sw_m, sw_s, sw_p, sw_edge, tick, clr, rem_z, last;
    logic [DEPTH-1:0] level_q;
    logic [DUR_W-1:0] dur_q [DEPTH];
    logic [DUR_W-1:0] rem_q;
    logic [IDX_W-1:0] cur_q, rd_q;
    logic [IDX_W:0] cnt_q;
    logic full_q, out_q, done_q, rec_q, play_q;

    assign sw_edge = sw_s != sw_p;
    assign rem_z = rem_q == '0;
    assign last = {1'b0, rd_q} == cnt_q - 1'b1;
    assign bus.play_out = out_q;
    assign bus.rec_busy = rec_q;
    assign bus.play_busy = play_q;
    assign bus.full = full_q;
    assign bus.entry_count = cnt_q;
    assign bus.play_done = done_q;

    record_playback_ctrl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Div_CLK(Div_CLK),
        .Rst_n(Rst_n),
        .clr(clr),
        .tick(tick)
    );

    always_ff @(posedge Div_CLK or negedge Rst_n) begin
        if (!Rst_n) {sw_m, sw_s, sw_p} <= '0;
        else {sw_m, sw_s, sw_p} <= {bus.sw_in, sw_m, sw_s};
    end

    always_ff @(posedge Div_CLK or negedge Rst_n) begin
        if (!Rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    // clr realigns the prescaler on every mode entry and on each playback wrap
    always_comb begin
        state_d = state_q;
        clr = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = bus.stop ? IDLE : bus.rec_start ? RECORD :
                          (bus.play_start && cnt_q != '0) ? PLAY_LOAD : IDLE;
                clr = state_d != IDLE;
            end
            RECORD: state_d = (bus.stop || (sw_edge && cnt_q == FULL_N)) ? IDLE : RECORD;
            PLAY_LOAD: state_d = bus.stop ? IDLE : PLAY_RUN;
            PLAY_RUN: begin
                state_d = (bus.stop || (rem_z && last && !bus.loop_en)) ? IDLE : PLAY_RUN;
                clr = !bus.stop && rem_z && last && bus.loop_en;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Div_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) dur_q[i] <= '0;
            rem_q <= '0;
            cur_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            {full_q, out_q, done_q, rec_q, play_q} <= '0;
        end else begin
            rec_q <= state_d == RECORD;
            play_q <= state_d == PLAY_LOAD || state_d == PLAY_RUN;
            done_q <= 1'b0;
            if (state_q == IDLE && state_d == RECORD) begin
                full_q <= 1'b0;
                cur_q <= '0;
                level_q[0] <= sw_s;
                dur_q[0] <= '0;
                cnt_q <= (IDX_W + 1)'(1);
            end
            // a tick coinciding with an edge is credited to the entry being closed
            if (state_q == RECORD && !bus.stop) begin
                if (tick && dur_q[cur_q] != DUR_MAX) dur_q[cur_q] <= dur_q[cur_q] + 1'b1;
                if (sw_edge && cnt_q == FULL_N) full_q <= 1'b1;
                else if (sw_edge) begin
                    cur_q <= cur_q + 1'b1;
                    level_q[cur_q + 1'b1] <= sw_s;
                    dur_q[cur_q + 1'b1] <= '0;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (state_q == PLAY_LOAD) begin
                rd_q <= '0;
                rem_q <= dur_q[0];
                out_q <= !bus.stop && level_q[0];
            end
            if (state_q == PLAY_RUN) begin
                if (bus.stop) out_q <= 1'b0;
                else if (!rem_z) rem_q <= tick ? rem_q - 1'b1 : rem_q;
                else if (!last) begin
                    rd_q <= rd_q + 1'b1;
                    rem_q <= dur_q[rd_q + 1'b1];
                    out_q <= level_q[rd_q + 1'b1];
                end else if (bus.loop_en) begin
                    rd_q <= '0;
                    rem_q <= dur_q[0];
                    out_q <= level_q[0];
                end else begin
                    out_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_record_playback_ctrl.sv
// tb_record_playback_ctrl: scoreboard bench for record_playback_ctrl with TICK_DIV=4
module tb_record_playback_ctrl;
    logic Div_CLK = 1'b0;
    logic Rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic exp_q[$];

    record_playback_ctrl_if #(.IDX_W(3)) bus ();

    record_playback_ctrl #(.DEPTH(8), .IDX_W(3), .DUR_W(7), .TICK_DIV(4)) dut (
        .Div_CLK(Div_CLK),
        .Rst_n(Rst_n),
        .bus(bus)
    );

    always #5 Div_CLK = ~Div_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmd(input logic r, input logic p, input logic s);
        @(negedge Div_CLK);
        bus.rec_start = r;
        bus.play_start = p;
        bus.stop = s;
        @(negedge Div_CLK);
        bus.rec_start = 1'b0;
        bus.play_start = 1'b0;
        bus.stop = 1'b0;
    endtask

    task automatic push_seg(input logic lvl, input int n);
        repeat (n) exp_q.push_back(lvl);
    endtask

    task automatic drain();
        while (exp_q.size() != 0) begin
            @(negedge Div_CLK);
            chk("play_out", bus.play_out, exp_q.pop_front());
        end
    endtask

    task automatic play_and_drain();
        cmd(1'b0, 1'b1, 1'b0);
        chk("play_busy_load", bus.play_busy, 1);
        drain();
    endtask

    task automatic check_done();
        @(negedge Div_CLK);
        chk("end_out", bus.play_out, 0);
        chk("play_done", bus.play_done, 1);
        chk("end_busy", bus.play_busy, 0);
        @(negedge Div_CLK);
        chk("done_pulse", bus.play_done, 0);
    endtask

    // entry0 = low for 10 ticks, entry1 = high for 5 ticks
    task automatic rec_10_5();
        bus.sw_in = 1'b0;
        repeat (4) @(negedge Div_CLK);
        cmd(1'b1, 1'b0, 1'b0);
        repeat (39) @(negedge Div_CLK);
        bus.sw_in = 1'b1;
        repeat (21) @(negedge Div_CLK);
        cmd(1'b0, 1'b0, 1'b1);
        chk("rec_count", bus.entry_count, 2);
        chk("rec_busy_off", bus.rec_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        {bus.sw_in, bus.rec_start, bus.play_start, bus.stop, bus.loop_en} = '0;
        repeat (3) @(negedge Div_CLK);
        chk("rst_out", bus.play_out, 0);
        chk("rst_rec", bus.rec_busy, 0);
        chk("rst_play", bus.play_busy, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_count", bus.entry_count, 0);
        chk("rst_done", bus.play_done, 0);
        Rst_n = 1'b1;
        cmd(1'b0, 1'b1, 1'b0);
        chk("empty_play", bus.play_busy, 0);
        @(negedge Div_CLK);
        chk("empty_play2", bus.play_busy, 0);

        cmd(1'b1, 1'b0, 1'b0);
        chk("rec_busy", bus.rec_busy, 1);
        chk("rec_first", bus.entry_count, 1);
        for (int k = 0; k < 3; k++) begin
            repeat (k == 0 ? 7 : 8) @(negedge Div_CLK);
            bus.sw_in = ~bus.sw_in;
        end
        repeat (6) @(negedge Div_CLK);
        chk("mid_count", bus.entry_count, 4);
        #3 Rst_n = 1'b0;
        #1;
        chk("async_count", bus.entry_count, 0);
        chk("async_rec", bus.rec_busy, 0);
        chk("async_out", bus.play_out, 0);
        chk("async_full", bus.full, 0);
        @(negedge Div_CLK);
        Rst_n = 1'b1;

        rec_10_5();
        chk("rec_full", bus.full, 0);
        push_seg(1'b0, 40);
        push_seg(1'b1, 20);
        play_and_drain();
        check_done();
        chk("count_stable", bus.entry_count, 2);

        bus.loop_en = 1'b1;
        push_seg(1'b0, 40);
        push_seg(1'b1, 20);
        for (int k = 0; k < 2; k++) begin
            push_seg(1'b0, 41);
            push_seg(1'b1, 20);
        end
        push_seg(1'b0, 41);
        push_seg(1'b1, 5);
        play_and_drain();
        cmd(1'b0, 1'b0, 1'b1);
        chk("stop_out", bus.play_out, 0);
        chk("stop_busy", bus.play_busy, 0);
        chk("stop_done", bus.play_done, 0);
        @(negedge Div_CLK);
        chk("stop_done2", bus.play_done, 0);
        bus.loop_en = 1'b0;

        bus.sw_in = 1'b1;
        repeat (4) @(negedge Div_CLK);
        cmd(1'b1, 1'b0, 1'b0);
        repeat (800) @(negedge Div_CLK);
        cmd(1'b0, 1'b0, 1'b1);
        chk("sat_count", bus.entry_count, 1);
        push_seg(1'b1, 508);
        play_and_drain();
        check_done();

        cmd(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            repeat (k == 0 ? 7 : 8) @(negedge Div_CLK);
            bus.sw_in = ~bus.sw_in;
        end
        repeat (8) @(negedge Div_CLK);
        chk("ovf_full", bus.full, 1);
        chk("ovf_count", bus.entry_count, 8);
        chk("ovf_idle", bus.rec_busy, 0);
        for (int k = 0; k < 8; k++) push_seg(k % 2 == 0, 8);
        play_and_drain();
        check_done();
        cmd(1'b1, 1'b0, 1'b0);
        chk("full_clear", bus.full, 0);
        cmd(1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
